mmu: RTL and testbench

//  Responder end of the CPU<->MMU request bus: accepts one byte/word read or write, performs it, returns done+rdata.

---
 rtl/mmu_pkg.sv | 64 ++++++
 rtl/mmu_hram.sv | 28 ++
 rtl/mmu.sv | 225 ++++++++++++++++++++++
 tb/tb_mmu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared bus types, memory-map constants and address helpers for the MMU.
package mmu_pkg;

    typedef enum logic [1:0] {
        BUS_OP_IDLE  = 2'd0,
        BUS_OP_READ  = 2'd1,
        BUS_OP_WRITE = 2'd2
    } bus_op_t;

    typedef enum logic {
        BUS_SIZE_BYTE = 1'b0,
        BUS_SIZE_WORD = 1'b1
    } bus_size_t;

    typedef enum logic [1:0] {
        REG_EXT      = 2'd0,
        REG_HRAM     = 2'd1,
        REG_IE       = 2'd2,
        REG_UNUSABLE = 2'd3
    } mmu_region_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LO_ACC = 2'd1,
        ST_HI_ACC = 2'd2,
        ST_RESP   = 2'd3
    } mmu_state_t;

    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [15:0] IE_ADDR  = 16'hFFFF;
    localparam logic [15:0] ECHO_LO  = 16'hE000;
    localparam logic [15:0] ECHO_HI  = 16'hFDFF;
    localparam logic [15:0] UNUSE_LO = 16'hFEA0;
    localparam logic [15:0] UNUSE_HI = 16'hFEFF;

    // Classify one byte address; IE is checked first because it sits just above HRAM.
    function automatic mmu_region_t decode_region(input logic [15:0] a);
        if (a == IE_ADDR) begin
            return REG_IE;
        end else if ((a >= HRAM_LO) && (a <= HRAM_HI)) begin
            return REG_HRAM;
        end else if ((a >= UNUSE_LO) && (a <= UNUSE_HI)) begin
            return REG_UNUSABLE;
        end else begin
            return REG_EXT;
        end
    endfunction

    // Fold the echo window back onto work RAM when remapping is enabled.
    function automatic logic [15:0] echo_remap(input logic [15:0] a, input logic en);
        if (en && (a >= ECHO_LO) && (a <= ECHO_HI)) begin
            return a - 16'h2000;
        end else begin
            return a;
        end
    endfunction

    // Byte index into HRAM; only meaningful for addresses decoded as REG_HRAM.
    function automatic logic [6:0] hram_index(input logic [15:0] a);
        return 7'(a - HRAM_LO);
    endfunction

endpackage

// File: rtl/mmu_hram.sv
// High RAM: 127 bytes, synchronous write, combinational read.
module mmu_hram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] idx_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:126];

    // Store a byte on the clock edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i && (idx_i != 7'h7F)) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Index 7F has no storage behind it (that address is IE), so return a benign value.
    always_comb begin
        if (idx_i == 7'h7F) begin
            rdata_o = 8'hFF;
        end else begin
            rdata_o = mem_q[idx_i];
        end
    end

endmodule

// File: rtl/mmu.sv
// MMU responder: serves HRAM/IE internally, blocks the unusable window,
// and forwards everything else as byte cycles on the ext_* port.
module mmu
    import mmu_pkg::*;
#(
    parameter bit          ECHO_EN     = 1'b1,
    parameter int unsigned EXT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  bus_op_t     mmu_req_op,
    input  bus_size_t   mmu_req_size,
    input  logic [15:0] mmu_req_addr,
    input  logic [15:0] mmu_req_wdata,
    output logic        mmu_resp_done,
    output logic [15:0] mmu_resp_rdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata
);

    localparam bit          TMO_EN   = (EXT_TIMEOUT != 32'd0);
    localparam logic [15:0] TMO_LAST = 16'(EXT_TIMEOUT - 32'd1);

    mmu_state_t  state_q;
    logic        armed_q;
    logic        done_q;
    logic [15:0] rdata_q;
    logic        ext_req_q;
    logic        ext_we_q;
    logic [15:0] ext_addr_q;
    logic [7:0]  ext_wdata_q;
    logic [7:0]  ie_q;
    logic        started_q;
    logic [15:0] tmo_q;
    bus_op_t     op_q;
    bus_size_t   size_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;

    logic        in_acc_s;
    logic        is_write_s;
    logic [15:0] cur_addr_s;
    logic [15:0] hi_addr_s;
    mmu_region_t cur_region_s;
    mmu_region_t hi_region_s;
    logic [7:0]  cur_wbyte_s;
    logic [7:0]  hram_rdata_s;
    logic        hram_we_s;
    logic [7:0]  int_rbyte_s;
    logic        timeout_s;
    logic        need_issue_s;
    logic        byte_done_s;
    logic [7:0]  byte_val_s;

    // Address and data of the byte currently being worked on.
    always_comb begin
        in_acc_s     = (state_q == ST_LO_ACC) || (state_q == ST_HI_ACC);
        is_write_s   = (op_q == BUS_OP_WRITE);
        hi_addr_s    = addr_q + 16'd1;
        cur_addr_s   = (state_q == ST_HI_ACC) ? hi_addr_s : addr_q;
        cur_region_s = decode_region(cur_addr_s);
        hi_region_s  = decode_region(hi_addr_s);
        cur_wbyte_s  = (state_q == ST_HI_ACC) ? wdata_q[15:8] : wdata_q[7:0];
        hram_we_s    = in_acc_s && is_write_s && (cur_region_s == REG_HRAM);
        timeout_s    = TMO_EN && ext_req_q && !ext_ack && (tmo_q == TMO_LAST);
    end

    mmu_hram u_hram (
        .clk     (clk),
        .we_i    (hram_we_s),
        .idx_i   (hram_index(cur_addr_s)),
        .wdata_i (cur_wbyte_s),
        .rdata_o (hram_rdata_s)
    );

    // Read value for the internal targets; unusable space reads as all ones.
    always_comb begin
        case (cur_region_s)
            REG_HRAM: int_rbyte_s = hram_rdata_s;
            REG_IE:   int_rbyte_s = ie_q;
            default:  int_rbyte_s = 8'hFF;
        endcase
    end

    // Decide whether the current byte finishes this cycle, and with what value.
    always_comb begin
        byte_done_s  = 1'b0;
        byte_val_s   = 8'h00;
        need_issue_s = 1'b0;
        if (in_acc_s) begin
            if (cur_region_s != REG_EXT) begin
                byte_done_s = 1'b1;
                byte_val_s  = int_rbyte_s;
            end else if (!started_q) begin
                need_issue_s = 1'b1;
            end else if (ext_req_q && ext_ack) begin
                byte_done_s = 1'b1;
                byte_val_s  = ext_rdata;
            end else if (timeout_s) begin
                byte_done_s = 1'b1;
                byte_val_s  = 8'hFF;
            end else begin
                byte_done_s = 1'b0;
            end
        end else begin
            byte_done_s = 1'b0;
        end
        if (is_write_s) begin
            byte_val_s = 8'h00;
        end else begin
            byte_val_s = byte_val_s;
        end
    end

    // Request/response sequencer with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b1;
            done_q      <= 1'b0;
            rdata_q     <= 16'h0000;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            ie_q        <= 8'h00;
            started_q   <= 1'b0;
            tmo_q       <= 16'h0000;
            op_q        <= BUS_OP_IDLE;
            size_q      <= BUS_SIZE_BYTE;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            lo_q        <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (in_acc_s && is_write_s && (cur_region_s == REG_IE)) begin
                ie_q <= cur_wbyte_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!armed_q) begin
                        if (mmu_req_op == BUS_OP_IDLE) begin
                            armed_q <= 1'b1;
                        end
                    end else if (mmu_req_op != BUS_OP_IDLE) begin
                        op_q      <= mmu_req_op;
                        size_q    <= mmu_req_size;
                        addr_q    <= mmu_req_addr;
                        wdata_q   <= mmu_req_wdata;
                        tmo_q     <= 16'h0000;
                        state_q   <= ST_LO_ACC;
                        if (decode_region(mmu_req_addr) == REG_EXT) begin
                            ext_req_q   <= 1'b1;
                            ext_we_q    <= (mmu_req_op == BUS_OP_WRITE);
                            ext_addr_q  <= echo_remap(mmu_req_addr, ECHO_EN);
                            ext_wdata_q <= mmu_req_wdata[7:0];
                            started_q   <= 1'b1;
                        end else begin
                            started_q <= 1'b0;
                        end
                    end
                end
                ST_LO_ACC, ST_HI_ACC: begin
                    if (need_issue_s) begin
                        // Reached only for a high byte after an external low byte,
                        // which leaves the mandatory idle gap on ext_req.
                        ext_req_q   <= 1'b1;
                        ext_we_q    <= is_write_s;
                        ext_addr_q  <= echo_remap(cur_addr_s, ECHO_EN);
                        ext_wdata_q <= cur_wbyte_s;
                        started_q   <= 1'b1;
                        tmo_q       <= 16'h0000;
                    end else if (byte_done_s) begin
                        ext_req_q <= 1'b0;
                        tmo_q     <= 16'h0000;
                        if ((state_q == ST_LO_ACC) && (size_q == BUS_SIZE_WORD)) begin
                            lo_q    <= byte_val_s;
                            state_q <= ST_HI_ACC;
                            if ((hi_region_s == REG_EXT) && (cur_region_s != REG_EXT)) begin
                                ext_req_q   <= 1'b1;
                                ext_we_q    <= is_write_s;
                                ext_addr_q  <= echo_remap(hi_addr_s, ECHO_EN);
                                ext_wdata_q <= wdata_q[15:8];
                                started_q   <= 1'b1;
                            end else begin
                                started_q <= 1'b0;
                            end
                        end else begin
                            started_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_RESP;
                            if (state_q == ST_HI_ACC) begin
                                rdata_q <= {byte_val_s, lo_q};
                            end else begin
                                rdata_q <= {8'h00, byte_val_s};
                            end
                        end
                    end else if (ext_req_q) begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    armed_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mmu_resp_done  = done_q;
    assign mmu_resp_rdata = rdata_q;
    assign ext_req        = ext_req_q;
    assign ext_we         = ext_we_q;
    assign ext_addr       = ext_addr_q;
    assign ext_wdata      = ext_wdata_q;

endmodule

// File: tb/tb_mmu.sv
// Directed bench for mmu with a behavioural downstream byte responder.
module tb_mmu;
    import mmu_pkg::*;

    logic        clk;
    logic        reset;
    bus_op_t     mmu_req_op;
    bus_size_t   mmu_req_size;
    logic [15:0] mmu_req_addr;
    logic [15:0] mmu_req_wdata;
    logic        mmu_resp_done;
    logic [15:0] mmu_resp_rdata;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;

    int checks;
    int failures;

    logic [7:0]  ext_mem [0:65535];
    logic [15:0] log_addr [0:63];
    logic        log_we [0:63];
    int          starts, req_hi_cnt, wait_cnt, ack_delay, ack_budget, done_cnt;
    int          cyc_cnt, ack_cyc, done_cyc;
    logic        req_prev;

    mmu #(.ECHO_EN(1'b1), .EXT_TIMEOUT(32'd4)) dut (
        .clk            (clk),
        .reset          (reset),
        .mmu_req_op     (mmu_req_op),
        .mmu_req_size   (mmu_req_size),
        .mmu_req_addr   (mmu_req_addr),
        .mmu_req_wdata  (mmu_req_wdata),
        .mmu_resp_done  (mmu_resp_done),
        .mmu_resp_rdata (mmu_resp_rdata),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_ack        (ext_ack),
        .ext_rdata      (ext_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Downstream responder: acks after ack_delay request cycles while budget remains.
    always @(negedge clk) begin
        ext_ack = 1'b0;
        if (ext_req) begin
            req_hi_cnt = req_hi_cnt + 1;
            if (!req_prev) begin
                log_addr[starts % 64] = ext_addr;
                log_we[starts % 64]   = ext_we;
                starts   = starts + 1;
                wait_cnt = 0;
            end
            wait_cnt = wait_cnt + 1;
            if ((ack_budget > 0) && (wait_cnt == ack_delay)) begin
                ext_ack    = 1'b1;
                ack_budget = ack_budget - 1;
                ack_cyc    = cyc_cnt;
                ext_rdata  = ext_mem[ext_addr];
                if (ext_we) ext_mem[ext_addr] = ext_wdata;
            end
        end
        req_prev = ext_req;
        if (mmu_resp_done) done_cnt = done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its done pulse.
    task automatic txn(input bus_op_t o, input bus_size_t sz, input logic [15:0] a,
                       input logic [15:0] wd, input bit hold,
                       output logic [15:0] rd, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = 16'h0000;
        mmu_req_op    = o;
        mmu_req_size  = sz;
        mmu_req_addr  = a;
        mmu_req_wdata = wd;
        for (int i = 0; i < 60; i++) begin
            tick();
            lat = lat + 1;
            if (mmu_resp_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("txn_no_done", 32'd0, 32'd1);
        rd       = mmu_resp_rdata;
        done_cyc = cyc_cnt;
        if (!hold) begin
            mmu_req_op = BUS_OP_IDLE;
            tick();
            tick();
        end
    endtask

    logic [15:0] rd;
    int          lat, s, d, h;

    initial begin
        checks = 0; failures = 0; starts = 0; req_hi_cnt = 0; wait_cnt = 0;
        done_cnt = 0; cyc_cnt = 0; ack_cyc = 0; done_cyc = 0; req_prev = 1'b0;
        ack_delay = 1; ack_budget = 1000; ext_ack = 1'b0; ext_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) ext_mem[i] = 8'h00;
        reset = 1'b1; mmu_req_op = BUS_OP_IDLE; mmu_req_size = BUS_SIZE_BYTE;
        mmu_req_addr = 16'h0000; mmu_req_wdata = 16'h0000;

        repeat (3) tick();
        check_eq("rst_done", {31'd0, mmu_resp_done}, 32'd0);
        check_eq("rst_rdata", {16'd0, mmu_resp_rdata}, 32'h0000);
        check_eq("rst_ext_req", {31'd0, ext_req}, 32'd0);
        check_eq("rst_ext_we", {31'd0, ext_we}, 32'd0);
        check_eq("rst_ext_addr", {16'd0, ext_addr}, 32'h0000);
        check_eq("rst_ext_wdata", {24'd0, ext_wdata}, 32'h00);
        reset = 1'b0;
        tick();

        // HRAM byte write then read
        s = starts;
        txn(BUS_OP_WRITE, BUS_SIZE_BYTE, 16'hFF80, 16'h005A, 1'b0, rd, lat);
        check_eq("t1_wr_lat", lat, 32'd2);
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFF80, 16'h0000, 1'b0, rd, lat);
        check_eq("t1_rd_lat", lat, 32'd2);
        check_eq("t1_rd_data", {16'd0, rd}, 32'h005A);

        // Word straddling HRAM and IE
        txn(BUS_OP_WRITE, BUS_SIZE_WORD, 16'hFFFE, 16'hBEEF, 1'b0, rd, lat);
        check_eq("t2_wr_lat", lat, 32'd3);
        txn(BUS_OP_READ, BUS_SIZE_WORD, 16'hFFFE, 16'h0000, 1'b0, rd, lat);
        check_eq("t2_rd_lat", lat, 32'd3);
        check_eq("t2_rd_word", {16'd0, rd}, 32'hBEEF);
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFFFE, 16'h0000, 1'b0, rd, lat);
        check_eq("t2_hram7e", {16'd0, rd}, 32'h00EF);
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFFFF, 16'h0000, 1'b0, rd, lat);
        check_eq("t2_ie", {16'd0, rd}, 32'h00BE);
        check_eq("t12_no_ext", starts - s, 32'd0);
        ext_mem[16'h0000] = 8'h3C;
        s = starts;
        txn(BUS_OP_READ, BUS_SIZE_WORD, 16'hFFFF, 16'h0000, 1'b0, rd, lat);
        check_eq("t2_wrap_data", {16'd0, rd}, 32'h3CBE);
        check_eq("t2_wrap_starts", starts - s, 32'd1);
        check_eq("t2_wrap_addr", {16'd0, log_addr[s % 64]}, 32'h0000);

        // Echo remap on an external read
        ext_mem[16'hC123] = 8'h77;
        ack_delay = 3;
        s = starts;
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hE123, 16'h0000, 1'b0, rd, lat);
        check_eq("t3_data", {16'd0, rd}, 32'h0077);
        check_eq("t3_addr", {16'd0, log_addr[s % 64]}, 32'hC123);
        check_eq("t3_we", {31'd0, log_we[s % 64]}, 32'd0);
        check_eq("t3_ack_to_done", done_cyc - ack_cyc, 32'd1);

        // External word with op held after done
        ext_mem[16'hC000] = 8'h11;
        ext_mem[16'hC001] = 8'h22;
        ack_delay = 2;
        s = starts;
        txn(BUS_OP_READ, BUS_SIZE_WORD, 16'hC000, 16'h0000, 1'b1, rd, lat);
        check_eq("t4_data", {16'd0, rd}, 32'h2211);
        check_eq("t4_starts", starts - s, 32'd2);
        check_eq("t4_lo_addr", {16'd0, log_addr[s % 64]}, 32'hC000);
        check_eq("t4_hi_addr", {16'd0, log_addr[(s + 1) % 64]}, 32'hC001);
        d = done_cnt;
        repeat (6) tick();
        check_eq("t4_hold_done", done_cnt - d, 32'd0);
        check_eq("t4_hold_starts", starts - s, 32'd2);
        mmu_req_op = BUS_OP_IDLE;
        tick();
        tick();
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hC001, 16'h0000, 1'b0, rd, lat);
        check_eq("t4_rearm", {16'd0, rd}, 32'h0022);

        // Unusable window and timeout
        s = starts;
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFEA5, 16'h0000, 1'b0, rd, lat);
        check_eq("t5_unuse_rd", {16'd0, rd}, 32'h00FF);
        txn(BUS_OP_WRITE, BUS_SIZE_BYTE, 16'hFEA5, 16'h0012, 1'b0, rd, lat);
        check_eq("t5_unuse_lat", lat, 32'd2);
        check_eq("t5_unuse_no_ext", starts - s, 32'd0);
        ack_budget = 0;
        h = req_hi_cnt;
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'h8000, 16'h0000, 1'b0, rd, lat);
        check_eq("t5_tmo_data", {16'd0, rd}, 32'h00FF);
        check_eq("t5_tmo_lat", lat, 32'd5);
        check_eq("t5_tmo_req_cycles", req_hi_cnt - h, 32'd4);
        ack_budget = 1000;

        // External writes, with and without remap
        ack_delay = 1;
        s = starts;
        txn(BUS_OP_WRITE, BUS_SIZE_BYTE, 16'h9000, 16'h33A5, 1'b0, rd, lat);
        check_eq("tw_mem", {24'd0, ext_mem[16'h9000]}, 32'hA5);
        check_eq("tw_we", {31'd0, log_we[s % 64]}, 32'd1);
        txn(BUS_OP_WRITE, BUS_SIZE_WORD, 16'hF000, 16'h6B5C, 1'b0, rd, lat);
        check_eq("tw_echo_lo", {24'd0, ext_mem[16'hD000]}, 32'h5C);
        check_eq("tw_echo_hi", {24'd0, ext_mem[16'hD001]}, 32'h6B);

        // Reset in the middle of an external word read
        ack_budget = 1;
        s = starts;
        mmu_req_op = BUS_OP_READ; mmu_req_size = BUS_SIZE_WORD; mmu_req_addr = 16'hC000;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (starts == s + 2) break;
        end
        check_eq("t6_hi_started", starts - s, 32'd2);
        d = done_cnt;
        reset = 1'b1;
        mmu_req_op = BUS_OP_IDLE;
        tick();
        check_eq("t6_ext_req_low", {31'd0, ext_req}, 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        check_eq("t6_no_done", done_cnt - d, 32'd0);
        ack_budget = 1000;
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFFFF, 16'h0000, 1'b0, rd, lat);
        check_eq("t6_ie_reset", {16'd0, rd}, 32'h0000);
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hFF80, 16'h0000, 1'b0, rd, lat);
        check_eq("t6_hram_kept", {16'd0, rd}, 32'h005A);
        txn(BUS_OP_READ, BUS_SIZE_BYTE, 16'hC000, 16'h0000, 1'b0, rd, lat);
        check_eq("t6_after_reset", {16'd0, rd}, 32'h0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
